// File: rtl/phase_arbiter_pkg.sv
// Shared encodings for the phase arbiter: per-approach signal codes, controller
// phase codes, timer width and a helper that builds the packed signal bus.
package phase_arbiter_pkg;

  localparam int unsigned TimerW = 8;
  localparam int unsigned NumApp = 4;

  // Per-approach signal field encoding (3 is never driven).
  typedef enum logic [1:0] {
    SigRed    = 2'd0,
    SigYellow = 2'd1,
    SigGreen  = 2'd2
  } sig_e;

  // Controller phase encoding, also exported on the phase output.
  typedef enum logic [1:0] {
    PhAllRed = 2'd0,
    PhGreen  = 2'd1,
    PhYellow = 2'd2
  } phase_e;

  // Packed signal bus: only the granted approach is ever non-red.
  function automatic logic [2*NumApp-1:0] sig_encode(phase_e ph, logic [1:0] g);
    logic [2*NumApp-1:0] s;
    s = '0;
    if (ph == PhGreen) begin
      s[{g, 1'b0} +: 2] = SigGreen;
    end else if (ph == PhYellow) begin
      s[{g, 1'b0} +: 2] = SigYellow;
    end
    return s;
  endfunction

endpackage

// File: rtl/phase_arbiter_if.sv
// Demand/signal bundle between the traffic controller and its environment.
//   req   : level demand per approach (bit 0 = main road)
//   emerg : level emergency preemption per approach (PHASE_EMERG_EN only)
//   sig   : 2-bit signal per approach, approach i on sig[2i+1:2i]
//   grant : approach currently owning the intersection
//   phase : ALLRED=0, GREEN=1, YELLOW=2
// master drives demand, slave (the controller) drives the signals.
// Macro PHASE_EMERG_EN adds the emerg lines.
interface phase_arbiter_if;
  logic [3:0] req;
`ifdef PHASE_EMERG_EN
  logic [3:0] emerg;
`endif
  logic [7:0] sig;
  logic [1:0] grant;
  logic [1:0] phase;

`ifdef PHASE_EMERG_EN
  modport master (output req, output emerg, input sig, input grant, input phase);
  modport slave  (input req, input emerg, output sig, output grant, output phase);
`else
  modport master (output req, input sig, input grant, input phase);
  modport slave  (input req, output sig, output grant, output phase);
`endif
endinterface

// File: rtl/phase_arbiter_rr_pick4.sv
// Combinational 4-way round-robin picker.
//   grant  : current owner; the scan starts at grant+1 and ends at grant
//   req    : demand per approach
//   winner : first requesting approach in scan order, 0 when nobody requests
module rr_pick4 (
  input  logic [1:0] grant,
  input  logic [3:0] req,
  output logic [1:0] winner
);

  logic       found;
  logic [1:0] idx;

  always_comb begin
    winner = 2'd0;
    found  = 1'b0;
    idx    = grant;
    for (int k = 1; k <= 4; k++) begin
      idx = grant + 2'(k);
      if (!found && req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/phase_arbiter.sv
// Four-approach traffic phase controller: ALLRED -> GREEN -> YELLOW -> ALLRED.
//   clk : sole clock, rising edge
//   rst : asynchronous active-high reset (forces ALLRED, all red, grant 0)
//   bus : phase_arbiter_if.slave (req/emerg in, sig/grant/phase out, all registered)
// Optional feature: define PHASE_EMERG_EN for emergency preemption via bus.emerg.
module phase_arbiter
  import phase_arbiter_pkg::*;
#(
  parameter int unsigned MIN_GREEN = 8,
  parameter int unsigned MAX_GREEN = 20,
  parameter int unsigned YELLOW_T  = 3,
  parameter int unsigned ALLRED_T  = 2
) (
  input logic           clk,
  input logic           rst,
  phase_arbiter_if.slave bus
);

  localparam logic [TimerW-1:0] MinM1    = TimerW'(MIN_GREEN - 1);
  localparam logic [TimerW-1:0] MaxM1    = TimerW'(MAX_GREEN - 1);
  localparam logic [TimerW-1:0] YellowM1 = TimerW'(YELLOW_T - 1);
  localparam logic [TimerW-1:0] AllRedM1 = TimerW'(ALLRED_T - 1);

  phase_e              phase_q, phase_d;
  logic [1:0]          grant_q, grant_d;
  logic [TimerW-1:0]   timer_q, timer_d;
  logic [7:0]          sig_q;

  logic [1:0]          rr_winner;
  logic [1:0]          winner;
  logic [3:0]          gmask;
  logic                others_pending;
  logic                go_yellow;

  rr_pick4 u_pick (
    .grant  (grant_q),
    .req    (bus.req),
    .winner (rr_winner)
  );

`ifdef PHASE_EMERG_EN
  logic [1:0] emerg_pick;

  // Lowest-index emergency wins outright.
  always_comb begin
    emerg_pick = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (bus.emerg[k]) emerg_pick = 2'(k);
    end
  end

  assign winner = (|bus.emerg) ? emerg_pick : rr_winner;
`else
  assign winner = rr_winner;
`endif

  // Green exit decision.
  always_comb begin
    gmask          = 4'b0001 << grant_q;
    // A side approach that has lost its demand hands back to the main road.
    others_pending = (|(bus.req & ~gmask)) || ((grant_q != 2'd0) && !bus.req[grant_q]);
    // ">=" on the max bound so a green that outlived the timer range still yields.
    go_yellow      = others_pending &&
                     (((timer_q >= MinM1) && !bus.req[grant_q]) || (timer_q >= MaxM1));
`ifdef PHASE_EMERG_EN
    if (bus.emerg[grant_q]) begin
      go_yellow = 1'b0;
    end else if (|(bus.emerg & ~gmask)) begin
      go_yellow = 1'b1;
    end
`endif
  end

  always_comb begin
    phase_d = phase_q;
    grant_d = grant_q;
    timer_d = (timer_q == '1) ? timer_q : timer_q + 1'b1;
    unique case (phase_q)
      PhAllRed: begin
        if (timer_q >= AllRedM1) begin
          phase_d = PhGreen;
          grant_d = winner;
          timer_d = '0;
        end
      end
      PhGreen: begin
        if (go_yellow) begin
          phase_d = PhYellow;
          timer_d = '0;
        end
      end
      PhYellow: begin
        if (timer_q >= YellowM1) begin
          phase_d = PhAllRed;
          timer_d = '0;
        end
      end
      default: begin
        phase_d = PhAllRed;
        timer_d = '0;
      end
    endcase
  end

  // Signals are registered from next-state so they line up with phase/grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q <= PhAllRed;
      grant_q <= 2'd0;
      timer_q <= '0;
      sig_q   <= '0;
    end else begin
      phase_q <= phase_d;
      grant_q <= grant_d;
      timer_q <= timer_d;
      sig_q   <= sig_encode(phase_d, grant_d);
    end
  end

  assign bus.sig   = sig_q;
  assign bus.grant = grant_q;
  assign bus.phase = phase_q;

endmodule
